// File: rtl/serial_addsub.sv
// Digit-serial add/subtract engine: DIGIT bits per cycle, WIDTH/DIGIT cycles per operation.
// The result registers are written only at completion, so the last result stays visible while the next operation runs.
module serial_addsub #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sub,
    input  logic             ld,
    input  logic             st,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    // state  | meaning
    // IDLE   | no operands held, waiting for ld
    // LOADED | operands and mode captured, waiting for st
    // RUN    | one digit processed per edge
    // DONE   | result registered and held
    typedef enum logic [1:0] {IDLE, LOADED, RUN, DONE} state_e;

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT:0]   dsum;
    logic [WIDTH-1:0] psum_shift;

    assign dsum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    // New digit enters at the top; after N digits the LSB digit has reached bit 0.
    assign psum_shift = (psum_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        if (state_q != RUN && ld) begin
            a_d     = in1;
            b_d     = sub ? ~in2 : in2;
            carry_d = sub;
            a_msb_d = in1[WIDTH-1];
            b_msb_d = sub ? ~in2[WIDTH-1] : in2[WIDTH-1];
        end

        case (state_q)
            IDLE, DONE: begin
                if (ld) begin
                    state_d = st ? RUN : LOADED;
                    cnt_d   = '0;
                end
            end
            LOADED: begin
                if (st) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = dsum[DIGIT];
                psum_d  = psum_shift;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    sum_d   = psum_shift;
                    cout_d  = dsum[DIGIT];
                    ovf_d   = (a_msb_q == b_msb_q) && (psum_shift[WIDTH-1] != a_msb_q);
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and random checks of serial_addsub at DIGIT = 1, 4 and 32 (WIDTH = 32), sharing one stimulus.
module tb_serial_addsub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in1 = '0, in2 = '0;
    logic        sub = 1'b0, ld = 1'b0, st = 1'b0;

    logic [31:0] sum1, sum4, sum32;
    logic        cout1, cout4, cout32, ovf1, ovf4, ovf32;
    logic        busy1, busy4, busy32, done1, done4, done32;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] prev1 = '0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(32), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2), .sub(sub), .ld(ld), .st(st),
        .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1), .done(done1));
    serial_addsub #(.WIDTH(32), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2), .sub(sub), .ld(ld), .st(st),
        .sum(sum4), .cout(cout4), .ovf(ovf4), .busy(busy4), .done(done4));
    serial_addsub #(.WIDTH(32), .DIGIT(32)) u_d32 (
        .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2), .sub(sub), .ld(ld), .st(st),
        .sum(sum32), .cout(cout32), .ovf(ovf32), .busy(busy32), .done(done32));

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] e_sum;
        logic        e_cout;
        logic        e_ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after the edge that accepted st; waits for completion of every instance.
    task automatic wait_done(input logic [31:0] e_sum, input logic e_cout, input logic e_ovf,
                             input bit disturb);
        int lat1 = 0, lat4 = 0, lat32 = 0;
        logic [31:0] s1 = 'x, s4 = 'x, s32 = 'x;
        logic [2:0]  c = 'x, o = 'x;
        chk("busy_after_start", {31'b0, busy1}, 32'd1);
        chk("done_after_start", {31'b0, done1}, 32'd0);
        for (int e = 1; e <= 40 && lat1 == 0; e++) begin
            if (disturb && e == 5) begin
                ld = 1'b1; st = 1'b1; sub = 1'b1;
                in1 = 32'hDEADBEEF; in2 = 32'h12345678;
            end
            if (disturb && e == 6) begin
                ld = 1'b0; st = 1'b0;
            end
            step();
            if (e == 16 && lat1 == 0 && !done1) chk("sum_held_in_run", sum1, prev1);
            if (done1 && lat1 == 0)   begin lat1 = e;  s1 = sum1;   c[0] = cout1;  o[0] = ovf1;  end
            if (done4 && lat4 == 0)   begin lat4 = e;  s4 = sum4;   c[1] = cout4;  o[1] = ovf4;  end
            if (done32 && lat32 == 0) begin lat32 = e; s32 = sum32; c[2] = cout32; o[2] = ovf32; end
        end
        chk("latency_d1", lat1, 32'd32);
        chk("sum_d1", s1, e_sum);
        chk("cout_d1", {31'b0, c[0]}, {31'b0, e_cout});
        chk("ovf_d1", {31'b0, o[0]}, {31'b0, e_ovf});
        chk("busy_at_done", {31'b0, busy1}, 32'd0);
        if (!disturb) begin
            chk("latency_d4", lat4, 32'd8);
            chk("latency_d32", lat32, 32'd1);
            chk("sum_d4", s4, e_sum);
            chk("sum_d32", s32, e_sum);
            chk("cout_d4_d32", {30'b0, c[2:1]}, {30'b0, e_cout, e_cout});
            chk("ovf_d4_d32", {30'b0, o[2:1]}, {30'b0, e_ovf, e_ovf});
        end
        prev1 = e_sum;
    endtask

    task automatic do_op(input vec_t v, input bit disturb);
        in1 = v.a; in2 = v.b; sub = v.s; ld = 1'b1; st = 1'b1;
        step();
        ld = 1'b0; st = 1'b0;
        wait_done(v.e_sum, v.e_cout, v.e_ovf, disturb);
    endtask

    function automatic vec_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        vec_t v;
        logic [31:0] bb;
        logic [32:0] r;
        bb = s ? ~b : b;
        r  = {1'b0, a} + {1'b0, bb} + {32'b0, s};
        v.a = a; v.b = b; v.s = s;
        v.e_sum  = r[31:0];
        v.e_cout = r[32];
        v.e_ovf  = (a[31] == bb[31]) && (r[31] != a[31]);
        return v;
    endfunction

    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0};
        vecs[3] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[4] = '{32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b1, 1'b0};
        vecs[5] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[6] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[7] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};

        #12;
        chk("reset_sum", sum1, 32'd0);
        chk("reset_flags", {27'b0, cout1, ovf1, busy1, done1, busy32}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // st alone in IDLE does nothing
        step();
        st = 1'b1; step(); st = 1'b0; step();
        chk("st_alone_idle", {28'b0, busy1, done1, busy32, done32}, 32'd0);

        foreach (vecs[i]) do_op(vecs[i], 1'b0);

        // st alone in DONE: done and result hold
        st = 1'b1; step(); st = 1'b0; step();
        chk("st_alone_done", {30'b0, done1, busy1}, 32'd2);
        chk("st_alone_done_sum", sum1, 32'h00000000);

        // ld, operands change, st two cycles later
        in1 = 32'd100; in2 = 32'd23; sub = 1'b0; ld = 1'b1; step();
        ld = 1'b0; in1 = 32'hFFFF0000; in2 = 32'h0000FFFF; sub = 1'b1; step(); step();
        chk("loaded_not_busy", {31'b0, busy1}, 32'd0);
        st = 1'b1; step(); st = 1'b0;
        wait_done(32'd123, 1'b0, 1'b0, 1'b0);

        // reload while LOADED: the second ld wins
        in1 = 32'd1; in2 = 32'd1; sub = 1'b0; ld = 1'b1; step();
        in1 = 32'd40; in2 = 32'd2; sub = 1'b1; step();
        ld = 1'b0; st = 1'b1; step(); st = 1'b0;
        wait_done(32'd38, 1'b1, 1'b0, 1'b0);

        // ld/st pulsed mid-RUN are ignored by the DIGIT=1 engine
        do_op('{32'h00001000, 32'h00000234, 1'b0, 32'h00001234, 1'b0, 1'b0}, 1'b1);

        // reset at cycle 10 of RUN clears outputs immediately
        in1 = 32'd9; in2 = 32'd9; sub = 1'b0; ld = 1'b1; st = 1'b1; step();
        ld = 1'b0; st = 1'b0;
        for (int k = 0; k < 10; k++) step();
        rst_n = 1'b0; #1;
        chk("rst_mid_sum", sum1, 32'd0);
        chk("rst_mid_flags", {27'b0, cout1, ovf1, busy1, done1, busy4}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        prev1 = '0;
        do_op(model(32'hCAFEF00D, 32'h0BADBEEF, 1'b0), 1'b0);

        for (int r = 0; r < 10; r++)
            do_op(model($urandom, $urandom, 1'($urandom_range(0, 1))), 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised, digit-serial add/subtract unit. Successor to the 32-bit bit-serial adder.
- Adds configurable operand width, digit size (bits processed per cycle), a subtract mode, a signed-overflow flag, async reset and a held result register.
- Intended as a small-area arithmetic engine for control datapaths where latency is traded for gate count.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 1, bits processed per RUN cycle; must satisfy 1 <= DIGIT <= WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in1  in  WIDTH  operand A, sampled on an accepted ld
- in2  in  WIDTH  operand B, sampled on an accepted ld
- sub  in  1  mode, sampled with ld; 0 = A+B, 1 = A-B
- ld  in  1  load operands and mode
- st  in  1  start operation
- sum  out  WIDTH  result; updated only at completion, held otherwise
- cout  out  1  carry out of MSB; in subtract mode, 1 = no borrow
- ovf  out  1  two's-complement signed overflow of the completed operation
- busy  out  1  high while in RUN
- done  out  1  high in DONE

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; all operand registers, carry and counter cleared; sum=0, cout=0, ovf=0, busy=0, done=0.
- Reset mid-RUN aborts the operation. Outputs go to reset values immediately and no result is written.
- Define N = WIDTH/DIGIT. The counter is clog2(N+1) bits wide.
- State IDLE:
  - ld=1, st=0: load in1, in2 and sub; go to LOADED.
  - ld=1, st=1: load and start in the same edge; go to RUN.
  - st alone: ignored.
- State LOADED:
  - ld=1 reloads the operands and mode (st=0 stays in LOADED; st=1 goes to RUN with the new operands).
  - st=1 with ld=0: go to RUN.
- On the load edge:
  - A register = in1.
  - B register = sub ? ~in2 : in2.
  - carry = sub.
  - Operand sign bits A[WIDTH-1] and B'[WIDTH-1] are captured.
- On the RUN entry edge: counter = 0; busy=1; done=0.
- State RUN, per edge:
  - {c, d} = A[DIGIT-1:0] + B'[DIGIT-1:0] + carry.
  - A and B' shift right by DIGIT.
  - d enters the top DIGIT bits of the partial-sum shift register.
  - carry = c; counter increments.
- Completion: on the edge where counter = N-1, the last digit is processed and the following are registered:
  - sum = the final partial-sum register.
  - cout = final carry.
  - ovf = (a_msb == b'_msb) && (sum_msb != a_msb).
  - State goes to DONE, done=1, busy=0.
- Latency: N edges from the accepting st edge to done=1. DIGIT=1, WIDTH=32 gives 32 cycles; DIGIT=4 gives 8 cycles.
- ld and st are ignored throughout RUN. No restart or abort is possible except via reset.
- State DONE:
  - done stays high and sum/cout/ovf hold.
  - ld or ld+st is treated exactly as in IDLE and clears done on that edge.
  - st alone: ignored.
- sum, cout and ovf change only at completion or reset. A new operation in flight does not disturb the previous result.
- Arithmetic is modulo 2^WIDTH. Carry does not propagate between successive operations.

Test Plan:
- WIDTH=32, DIGIT=1: ld+st with in1=1, in2=2, sub=0 -> busy for 32 cycles, then done=1, sum=3, cout=0, ovf=0.
- ld+st with in1=32'hFFFFFFFF, in2=1 -> sum=0, cout=1, ovf=0. Then ld+st with in1=in2=32'hFFFFFFFF -> sum=32'hFFFFFFFE, cout=1; the previous sum=0 stays visible until completion.
- sub=1 with in1=5, in2=7 -> sum=32'hFFFFFFFE, cout=0. Then sub=1 with in1=7, in2=5 -> sum=2, cout=1.
- Overflow: in1=32'h7FFFFFFF, in2=1, add -> sum=32'h80000000, ovf=1. Subtract with in1=32'h80000000, in2=1 -> sum=32'h7FFFFFFF, ovf=1.
- DIGIT=4 and DIGIT=32 instances with random operands vs a reference model: latency is exactly 8 and 1 cycles respectively; results match.
- Control corner cases:
  - st without a prior ld in IDLE -> no activity.
  - ld then st two cycles later -> result uses the loaded values.
  - ld/st pulsed mid-RUN -> ignored; result unchanged.
  - rst_n low at cycle 10 of RUN -> outputs 0, state IDLE; a subsequent ld+st completes normally.
